tl_burst_master: RTL

- TileLink-UH initiator (A out, D in) for the 128-bit testbench memory fabric.
- Converts a simple request/data-stream interface into single-beat Get (opcode 4) and multi-beat PutFullData (opcode 0) transactions.
- Returns AccessAckData beats or AccessAck completion to the requester.
- Drives the memory-model slave; serves as refill/writeback engine for cache and bench traffic.

---
 rtl/tl_burst_master.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/tl_burst_master.sv
// TileLink-UH initiator: request/write-stream front end issuing single-beat Get and multi-beat PutFullData.
// Define TL_MST_PROTO_CHECK_EN to enable the sticky D-channel protocol checker driving proto_err.
module tl_burst_master #(
  parameter int MAX_SIZE  = 6,
  parameter int SOURCE_ID = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_wr,
  input  logic [31:0]  req_addr,
  input  logic [7:0]   req_size,
  input  logic         wdata_valid,
  output logic         wdata_ready,
  input  logic [127:0] wdata,
  output logic         rdata_valid,
  input  logic         rdata_ready,
  output logic [127:0] rdata,
  output logic         rdata_last,
  output logic         rdata_denied,
  output logic         wrsp_valid,
  output logic         wrsp_denied,
  output logic         proto_err,
  output logic [2:0]   tlmst_a_opcode,
  output logic [2:0]   tlmst_a_param,
  output logic [7:0]   tlmst_a_size,
  output logic [2:0]   tlmst_a_source,
  output logic [31:0]  tlmst_a_address,
  output logic [15:0]  tlmst_a_mask,
  output logic [127:0] tlmst_a_data,
  output logic         tlmst_a_corrupt,
  output logic         tlmst_a_valid,
  input  logic         tlmst_a_ready,
  input  logic [2:0]   tlmst_d_opcode,
  input  logic [1:0]   tlmst_d_param,
  input  logic [7:0]   tlmst_d_size,
  input  logic [2:0]   tlmst_d_source,
  input  logic [2:0]   tlmst_d_sink,
  input  logic         tlmst_d_denied,
  input  logic [127:0] tlmst_d_data,
  input  logic         tlmst_d_corrupt,
  input  logic         tlmst_d_valid,
  output logic         tlmst_d_ready
);

  localparam logic [7:0] MAX_SZ  = 8'(MAX_SIZE);
  localparam logic [2:0] SRC     = 3'(SOURCE_ID);
  localparam logic [2:0] OP_PUT  = 3'd0;
  localparam logic [2:0] OP_GET  = 3'd4;
  localparam logic [2:0] OP_ACK  = 3'd0;
  localparam logic [2:0] OP_ACKD = 3'd1;

  typedef enum logic [2:0] {IDLE, A_GET, D_DATA, A_PUT, D_ACK, ERR} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  size_q, size_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic        proto_flag;
  logic        ack_ok;
  logic        d_bad_common;
  logic [15:0] mask_base;
  logic [3:0]  mask_off;

  function automatic logic [8:0] beats_of(input logic [7:0] sz);
    if (sz < 8'd4) return 9'd1;
    return 9'd1 << (sz - 8'd4);
  endfunction

`ifdef TL_MST_PROTO_CHECK_EN
  assign ack_ok       = (tlmst_d_opcode == OP_ACK);
  assign d_bad_common = (tlmst_d_source != SRC) || (tlmst_d_size != size_q);
`else
  // Without the checker any D handshake in the ack phase closes the write.
  assign ack_ok       = 1'b1;
  assign d_bad_common = 1'b0;
`endif

  assign tlmst_a_param   = 3'd0;
  assign tlmst_a_corrupt = 1'b0;
  assign tlmst_a_source  = SRC;
  assign tlmst_a_address = addr_q;
  assign tlmst_a_size    = size_q;

  // Sub-beat transfers place the byte lanes at the size-aligned offset inside the 16-byte beat.
  always_comb begin
    mask_base = 16'h0001;
    mask_off  = addr_q[3:0];
    case (size_q[1:0])
      2'd0: begin mask_base = 16'h0001; mask_off = addr_q[3:0];          end
      2'd1: begin mask_base = 16'h0003; mask_off = {addr_q[3:1], 1'b0};  end
      2'd2: begin mask_base = 16'h000F; mask_off = {addr_q[3:2], 2'b00}; end
      default: begin mask_base = 16'h00FF; mask_off = {addr_q[3], 3'b000}; end
    endcase
    tlmst_a_mask = (size_q >= 8'd4) ? 16'hFFFF : (mask_base << mask_off);
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    size_d        = size_q;
    cnt_d         = cnt_q;
    wr_d          = wr_q;
    proto_flag    = 1'b0;
    req_ready     = 1'b0;
    wdata_ready   = 1'b0;
    rdata_valid   = 1'b0;
    rdata         = '0;
    rdata_last    = 1'b0;
    rdata_denied  = 1'b0;
    wrsp_valid    = 1'b0;
    wrsp_denied   = 1'b0;
    tlmst_a_valid = 1'b0;
    tlmst_a_opcode = OP_GET;
    tlmst_a_data  = '0;
    tlmst_d_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready     = 1'b1;
        // Stray D beats are swallowed so the fabric never stalls on us.
        tlmst_d_ready = 1'b1;
        if (tlmst_d_valid) proto_flag = 1'b1;
        if (req_valid) begin
          addr_d = req_addr;
          size_d = req_size;
          wr_d   = req_wr;
          if (req_size > MAX_SZ) begin
            cnt_d   = '0;
            state_d = ERR;
          end else begin
            cnt_d   = beats_of(req_size);
            state_d = req_wr ? A_PUT : A_GET;
          end
        end
      end
      A_GET: begin
        tlmst_a_valid  = 1'b1;
        tlmst_a_opcode = OP_GET;
        if (tlmst_a_ready) state_d = D_DATA;
      end
      D_DATA: begin
        rdata_valid   = tlmst_d_valid;
        tlmst_d_ready = rdata_ready;
        rdata         = tlmst_d_data;
        rdata_denied  = tlmst_d_denied | tlmst_d_corrupt;
        rdata_last    = (cnt_q == 9'd1);
        if (tlmst_d_valid && rdata_ready) begin
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_d = IDLE;
          if (d_bad_common || (tlmst_d_opcode != OP_ACKD)) proto_flag = 1'b1;
        end
      end
      A_PUT: begin
        tlmst_a_valid  = wdata_valid;
        tlmst_a_opcode = OP_PUT;
        tlmst_a_data   = wdata;
        wdata_ready    = tlmst_a_ready;
        if (wdata_valid && tlmst_a_ready) begin
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            // A fast slave may ack alongside the last beat; accept it here.
            tlmst_d_ready = 1'b1;
            state_d       = D_ACK;
            if (tlmst_d_valid) begin
              if (d_bad_common || !ack_ok) proto_flag = 1'b1;
              if (ack_ok) begin
                wrsp_valid  = 1'b1;
                wrsp_denied = tlmst_d_denied;
                state_d     = IDLE;
              end
            end
          end
        end
      end
      D_ACK: begin
        tlmst_d_ready = 1'b1;
        if (tlmst_d_valid) begin
          if (d_bad_common || !ack_ok) proto_flag = 1'b1;
          if (ack_ok) begin
            wrsp_valid  = 1'b1;
            wrsp_denied = tlmst_d_denied;
            state_d     = IDLE;
          end
        end
      end
      ERR: begin
        if (wr_q) begin
          wrsp_valid  = 1'b1;
          wrsp_denied = 1'b1;
          state_d     = IDLE;
        end else begin
          rdata_valid  = 1'b1;
          rdata_denied = 1'b1;
          rdata_last   = 1'b1;
          if (rdata_ready) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
    end
  end

`ifdef TL_MST_PROTO_CHECK_EN
  logic proto_err_q, proto_err_d;
  assign proto_err_d = proto_err_q | proto_flag;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) proto_err_q <= 1'b0;
    else     proto_err_q <= proto_err_d;
  end
  assign proto_err = proto_err_q;
  logic unused_d;
  assign unused_d = ^{tlmst_d_param, tlmst_d_sink};
`else
  assign proto_err = 1'b0;
  logic unused_d;
  assign unused_d = ^{tlmst_d_param, tlmst_d_sink, tlmst_d_opcode, tlmst_d_size,
                      tlmst_d_source, proto_flag, d_bad_common};
`endif

endmodule
